tqvp_vga_sprite_capture: RTL and testbench

Register-mapped TinyQV peripheral: the receive end of the team's 1024x768@60 sprite video output. Locks to incoming active-low HSYNC/VSYNC plus a 1-bit pixel on the input PMOD, maps the stream back to the 256x192 logical grid (scale 4), and captures one 8x8 logical window into a 64-bit bitmap. The bitmap uses the same bit order as the sprite engine's bitmap registers. It also measures line length and frame height, and raises an interrupt when a capture completes. Used for loopback self-test of the sprite engine and for capturing external 1bpp video.

---
 rtl/tqvp_vga_sprite_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_tqvp_vga_sprite_capture.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_vga_sprite_capture.sv
// VGA sprite capture peripheral: locks to XGA sync, captures an 8x8 logical window into a 64-bit bitmap.
// Optional HMEAS/VMEAS line/frame measurement is built when VGA_CAP_MEASURE_EN is defined.
module tqvp_vga_sprite_capture (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam logic [11:0] H_START   = 12'd296;
  localparam logic [11:0] H_END     = 12'd1320;
  localparam logic [9:0]  V_START   = 10'd35;
  localparam logic [9:0]  V_END     = 10'd803;
  localparam logic [11:0] H_SAT     = 12'd4095;
  localparam logic [9:0]  V_SAT     = 10'd1023;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic        hs_cur_q, hs_prev_q, vs_cur_q, vs_prev_q;
  logic        pix_cur_q, pix_dly_q;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [1:0]  state_q, state_d;
  logic [63:0] bitmap_q, bitmap_d;
  logic [15:0] capxy_q, capxy_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        nosync_q, nosync_d;

  logic        hs_fall_s, vs_fall_s, timeout_s;
  logic        wr_s, arm_s, clr_done_s, clr_nosync_s, busy_s;
  logic [11:0] hx_full_s;
  logic [9:0]  vy_s;
  logic [7:0]  lx_s, ly_s, dx_s, dy_s;
  logic        active_s, sample_s, in_win_s;
  logic [5:0]  bit_idx_s;
  logic [10:0] hmeas_s;
  logic [9:0]  vmeas_s;
  logic [15:0] rdata_s;
  logic        unused_s;

  assign hs_fall_s = hs_prev_q & ~hs_cur_q;
  assign vs_fall_s = vs_prev_q & ~vs_cur_q;

  assign wr_s         = (data_write_n != 2'b11);
  assign arm_s        = wr_s && (address == 6'h00) && data_in[0];
  assign clr_done_s   = wr_s && (address == 6'h01) && data_in[1];
  assign clr_nosync_s = wr_s && (address == 6'h01) && data_in[2];
  assign busy_s       = (state_q != S_IDLE);

  // The pixel is delayed one extra stage so it lines up with h_cnt after the edge is seen.
  assign hx_full_s = h_cnt_q - H_START;
  assign vy_s      = v_cnt_q - V_START;
  assign lx_s      = hx_full_s[9:2];
  assign ly_s      = vy_s[9:2];
  assign dx_s      = lx_s - capxy_q[7:0];
  assign dy_s      = ly_s - capxy_q[15:8];
  assign active_s  = (h_cnt_q >= H_START) && (h_cnt_q < H_END) &&
                     (v_cnt_q >= V_START) && (v_cnt_q < V_END);
  assign sample_s  = active_s && (hx_full_s[1:0] == 2'd2) && (vy_s[1:0] == 2'd2);
  assign in_win_s  = (lx_s >= capxy_q[7:0]) && (dx_s < 8'd8) &&
                     (ly_s >= capxy_q[15:8]) && (dy_s < 8'd8);
  assign bit_idx_s = {dy_s[2:0], dx_s[2:0]};

  // Line/frame counters; timeout fires once, on the cycle h_cnt reaches saturation.
  always_comb begin
    if (hs_fall_s) begin
      h_cnt_d = 12'd0;
    end else if (h_cnt_q == H_SAT) begin
      h_cnt_d = h_cnt_q;
    end else begin
      h_cnt_d = h_cnt_q + 12'd1;
    end
    if (vs_fall_s) begin
      v_cnt_d = 10'd0;
    end else if (hs_fall_s && (v_cnt_q != V_SAT)) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end
  end

  assign timeout_s = (h_cnt_d == H_SAT) && (h_cnt_q != H_SAT);

  // Capture FSM plus status flags; a DONE set outranks a same-cycle clear.
  always_comb begin
    state_d  = state_q;
    bitmap_d = bitmap_q;
    done_d   = clr_done_s ? 1'b0 : done_q;
    nosync_d = clr_nosync_s ? 1'b0 : nosync_q;
    if (arm_s) begin
      state_d  = S_ARMED;
      bitmap_d = 64'd0;
      done_d   = 1'b0;
      nosync_d = 1'b0;
    end else if (timeout_s) begin
      state_d  = S_IDLE;
      nosync_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_ARMED: state_d = vs_fall_s ? S_CAPTURE : S_ARMED;
        S_CAPTURE: begin
          if (sample_s && in_win_s) begin
            bitmap_d[bit_idx_s] = pix_dly_q;
          end else begin
            bitmap_d = bitmap_q;
          end
          if (vs_fall_s) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_CAPTURE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign capxy_d  = (wr_s && (address == 6'h04)) ? data_in[15:0] : capxy_q;
  assign irq_en_d = (wr_s && (address == 6'h00)) ? data_in[1] : irq_en_q;

  // Sync history, counters and control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_cur_q  <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_cur_q  <= 1'b1;
      vs_prev_q <= 1'b1;
      pix_cur_q <= 1'b0;
      pix_dly_q <= 1'b0;
      h_cnt_q   <= 12'd0;
      v_cnt_q   <= 10'd0;
      state_q   <= S_IDLE;
      bitmap_q  <= 64'd0;
      capxy_q   <= 16'd0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      nosync_q  <= 1'b0;
    end else begin
      hs_cur_q  <= ui_in[1];
      hs_prev_q <= hs_cur_q;
      vs_cur_q  <= ui_in[2];
      vs_prev_q <= vs_cur_q;
      pix_cur_q <= ui_in[0];
      pix_dly_q <= pix_cur_q;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      state_q   <= state_d;
      bitmap_q  <= bitmap_d;
      capxy_q   <= capxy_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      nosync_q  <= nosync_d;
    end
  end

`ifdef VGA_CAP_MEASURE_EN
  logic [10:0] hmeas_q, hmeas_d;
  logic [9:0]  vmeas_q, vmeas_d;

  // Period measurement latched on each sync fall, saturating at register width.
  always_comb begin
    if (hs_fall_s) begin
      hmeas_d = (h_cnt_q >= 12'd2047) ? 11'h7FF : (h_cnt_q[10:0] + 11'd1);
    end else begin
      hmeas_d = hmeas_q;
    end
    if (vs_fall_s) begin
      vmeas_d = (v_cnt_q == V_SAT) ? V_SAT : (v_cnt_q + 10'd1);
    end else begin
      vmeas_d = vmeas_q;
    end
  end

  // Measurement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hmeas_q <= 11'd0;
      vmeas_q <= 10'd0;
    end else begin
      hmeas_q <= hmeas_d;
      vmeas_q <= vmeas_d;
    end
  end

  assign hmeas_s = hmeas_q;
  assign vmeas_s = vmeas_q;
`else
  assign hmeas_s = 11'd0;
  assign vmeas_s = 10'd0;
`endif

  // Combinational register readback.
  always_comb begin
    case (address)
      6'h00:   rdata_s = {14'd0, irq_en_q, 1'b0};
      6'h01:   rdata_s = {13'd0, nosync_q, done_q, busy_s};
      6'h04:   rdata_s = capxy_q;
      6'h06:   rdata_s = bitmap_q[15:0];
      6'h08:   rdata_s = bitmap_q[31:16];
      6'h0A:   rdata_s = bitmap_q[47:32];
      6'h0C:   rdata_s = bitmap_q[63:48];
      6'h10:   rdata_s = {5'd0, hmeas_s};
      6'h12:   rdata_s = {6'd0, vmeas_s};
      default: rdata_s = 16'd0;
    endcase
  end

  assign data_out       = {16'd0, rdata_s};
  assign data_ready     = 1'b1;
  assign uo_out         = 8'd0;
  assign user_interrupt = done_q & irq_en_q;

  assign unused_s = &{1'b0, data_read_n, data_in[31:16], ui_in[7:3], hx_full_s[11:10]};

endmodule

// File: tb/tb_tqvp_vga_sprite_capture.sv
// Self-checking bench for tqvp_vga_sprite_capture: synthetic sync/pixel source driven from a
// logical image, expected bitmaps derived directly from the window-to-bit mapping.
`timescale 1ns/1ps
module tb_tqvp_vga_sprite_capture;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int checks = 0;
  int errors = 0;
  logic img [0:191][0:255];

`ifdef VGA_CAP_MEASURE_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  tqvp_vga_sprite_capture dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    data_in = {16'd0, d};
    data_write_n = 2'b00;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rdchk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    #1;
    check(tag, data_out, exp);
  endtask

  // One source line: HSYNC low for 2 clocks, VSYNC low for 4 clocks on line 0 only.
  task automatic line(input int vline, input int len);
    int hx, vy;
    logic p;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      hx = c - 296;
      vy = vline - 35;
      p = 1'b0;
      if (hx >= 0 && hx < 1024 && vy >= 0 && vy < 768) p = img[vy / 4][hx / 4];
      ui_in = {5'b00000, ~(vline == 0 && c < 4), (c >= 2), p};
    end
  endtask

  // Only lines that hold window sample points are drawn full width; the rest are short.
  task automatic frame(input int first, input int last, input int x, input int y);
    int vy, len;
    for (int l = first; l <= last; l++) begin
      vy = l - 35;
      len = 8;
      if (vy >= 0 && vy < 768 && vy % 4 == 2 && vy / 4 >= y && vy / 4 < y + 8)
        len = 296 + 4 * ((x + 8 > 256) ? 256 : x + 8);
      line(l, len);
    end
  endtask

  function automatic int frame_lines(input int y);
    return 35 + 4 * ((y + 8 > 192) ? 192 : y + 8);
  endfunction

  task automatic check_bitmap(input string tag, input int x, input int y);
    logic [63:0] e;
    e = 64'd0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (x + c < 256 && y + r < 192) e[r * 8 + c] = img[y + r][x + c];
    for (int w = 0; w < 4; w++)
      rdchk($sformatf("%s_bm%0d", tag, w), 6'(6 + 2 * w), {16'd0, e[16 * w +: 16]});
  endtask

  task automatic fill_random();
    logic [31:0] t;
    for (int y = 0; y < 192; y++)
      for (int x = 0; x < 256; x++) begin
        t = $urandom();
        img[y][x] = t[0];
      end
  endtask

  task automatic run_capture(input string tag, input int x, input int y, input logic irq);
    int nl;
    nl = frame_lines(y);
    wr(6'h04, {y[7:0], x[7:0]});
    wr(6'h00, {14'd0, irq, 1'b1});
    rdchk({tag, "_busy"}, 6'h01, 32'h1);
    frame(0, nl - 1, x, y);
    frame(0, 1, x, y);
    rdchk({tag, "_done"}, 6'h01, 32'h2);
    check_bitmap(tag, x, y);
    check({tag, "_irq"}, {31'd0, user_interrupt}, {31'd0, irq});
  endtask

  initial begin
    logic [5:0] regs [9];
    int len_r, nl;
    regs = '{6'h00, 6'h01, 6'h04, 6'h06, 6'h08, 6'h0A, 6'h0C, 6'h10, 6'h12};
    for (int y = 0; y < 192; y++)
      for (int x = 0; x < 256; x++) img[y][x] = 1'b0;
    ui_in = 8'h06;
    address = 6'h00;
    data_in = 32'd0;
    data_write_n = 2'b11;
    data_read_n = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) rdchk($sformatf("reset_reg%0h", regs[i]), regs[i], 32'd0);
    check("reset_irq", {31'd0, user_interrupt}, 32'd0);
    check("uo_out", {24'd0, uo_out}, 32'd0);
    check("data_ready", {31'd0, data_ready}, 32'd1);
    wr(6'h02, 16'hFFFF);
    rdchk("unmapped", 6'h02, 32'd0);

    // Line / frame measurement
    len_r = $urandom_range(1000, 1400);
    line(1000, len_r);
    line(1000, len_r);
    rdchk("hmeas_rand", 6'h10, MEAS ? len_r : 32'd0);
    line(1000, 1344);
    line(1000, 1344);
    rdchk("hmeas_1344", 6'h10, MEAS ? 32'd1344 : 32'd0);
    for (int l = 0; l < 806; l++) line(l, 8);
    line(0, 8);
    rdchk("vmeas_806", 6'h12, MEAS ? 32'd806 : 32'd0);
    rdchk("hmeas_short", 6'h10, MEAS ? 32'd8 : 32'd0);

    // Checkerboard at X=20, Y=10 with interrupt enabled
    for (int y = 0; y < 192; y++)
      for (int x = 0; x < 256; x++) img[y][x] = ((x + y) % 2 == 0);
    run_capture("checker", 20, 10, 1'b1);
    rdchk("ctrl_rd", 6'h00, 32'h2);
    wr(6'h01, 16'h0002);
    check("irq_clear", {31'd0, user_interrupt}, 32'd0);
    rdchk("status_clear", 6'h01, 32'h0);

    // Random images: right edge, bottom edge, interior
    fill_random();
    run_capture("right_edge", 252, $urandom_range(0, 40), 1'b0);
    fill_random();
    run_capture("bottom_edge", $urandom_range(0, 60), 188, 1'b0);
    fill_random();
    run_capture("interior", $urandom_range(0, 60), $urandom_range(0, 100), 1'b1);

    // Re-ARM during capture
    fill_random();
    nl = frame_lines(2);
    wr(6'h04, 16'h0203);
    wr(6'h00, 16'h0001);
    frame(0, 60, 3, 2);
    wr(6'h00, 16'h0001);
    for (int w = 0; w < 4; w++) rdchk($sformatf("rearm_zero%0d", w), 6'(6 + 2 * w), 32'd0);
    rdchk("rearm_busy", 6'h01, 32'h1);
    frame(61, nl - 1, 3, 2);
    frame(0, nl - 1, 3, 2);
    frame(0, 1, 3, 2);
    rdchk("rearm_done", 6'h01, 32'h2);
    check_bitmap("rearm", 3, 2);

    // Loss of HSYNC mid-capture
    wr(6'h00, 16'h0001);
    frame(0, 40, 3, 2);
    repeat (4200) @(negedge clk);
    rdchk("nosync_set", 6'h01, 32'h4);
    wr(6'h01, 16'h0004);
    rdchk("nosync_clear", 6'h01, 32'h0);

    // Reset mid-capture
    wr(6'h04, 16'h0000);
    wr(6'h00, 16'h0003);
    frame(0, 50, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 9; i++) rdchk($sformatf("rst_mid_reg%0h", regs[i]), regs[i], 32'd0);
    check("rst_mid_irq", {31'd0, user_interrupt}, 32'd0);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
